branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor that steers the fetch-stage PC of the pipelined RV32I core. It looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters and returns a predicted next PC in the same cycle. It carries each prediction alongside its instruction to Execute, resolves it against the actual outcome, and emits a mispredict flush plus recovery PC. It also trains the table there. It sits beside the PC register / PCNext mux and feeds the hazard unit's flush logic.

## Interface
- INDEX_BITS, 4, log2 of BTB entries (16); index = PC[INDEX_BITS+1:2], tag = PC[31:INDEX_BITS+2]
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Stall  in  1  fetch/decode stall from hazard unit
- PCF  in  32  current fetch PC
- PredTakenF  out  1  predict taken for PCF
- PredTargetF  out  32  predicted target; valid only when PredTakenF=1
- BranchE  in  1  instruction in Execute is a branch/jump
- TakenE  in  1  actual outcome in Execute
- TargetE  in  32  actual target computed in Execute
- PCE  in  32  PC of instruction in Execute
- MispredictE  out  1  flush F/D and redirect fetch
- RecoverPCE  out  32  redirect PC: TakenE ? TargetE : PCE+4

## Operation
- BTB entry: valid, tag, 32-bit target, 2-bit counter (SNT=00, WNT=01, WT=10, ST=11).
- Lookup (combinational): hit = valid & tag match; PredTakenF = hit & ctr[1]; PredTargetF = entry target.
- Tracking pipe: two internal slots, D and E, each {valid, pred_taken, pred_target}.
  - Normal cycle: F prediction → D slot, D slot → E slot.
  - Stall=1: D slot holds; E slot loads a bubble (valid=0).
  - MispredictE=1: D and E slots cleared next edge; overrides Stall.
- Resolution (E slot valid):
  - BranchE=1: mispredict if pred_taken≠TakenE, or both taken and pred_target≠TargetE.
  - BranchE=0 and pred_taken=1: mispredict; RecoverPCE=PCE+4.
  - E slot invalid: MispredictE=0, no training.
- Training (E slot valid & BranchE, at clk edge):
  - Hit at PCE: counter saturating +1 if TakenE, −1 otherwise; if TakenE, target ← TargetE.
  - Miss and TakenE: allocate (overwrite), valid=1, tag, target=TargetE, counter=WT.
  - Miss and not taken: no write.
- Counters saturate: ST+1=ST, SNT−1=SNT.
- Same-index lookup and update in the same cycle: lookup returns pre-update contents (no bypass).

## Timing
- Prediction: 0-cycle latency, combinational from PCF.
- Resolution: MispredictE / RecoverPCE combinational in Execute; PC mux takes RecoverPCE at the next edge.
- Table update visible to lookups from the cycle after the training edge.
- Reset (asynchronous, any time, incl. mid-stall or mid-mispredict):
  - All valid bits 0; counters WNT; slots invalid.
  - Outputs: PredTakenF=0, PredTargetF=0, MispredictE=0, RecoverPCE = combinational from inputs.
- PCF not word-aligned: PCF[1:0] ignored.

## Structure
- Shared package bp_pkg: counter enum bp_ctr_t, default INDEX_BITS, struct bp_slot_t {valid, pred_taken, pred_target}.
- Sub-module btb_table: storage array, combinational read port (PCF), one synchronous write port (index, tag, target, ctr, we); resets valid/counters.
- Top: slot pipeline, resolve logic, counter next-state function.

## Test plan
- Reset, PCF=0x100 → PredTakenF=0; BranchE with TakenE=0 at PCE=0x100 → MispredictE=0, no allocation.
- Branch at 0x40 taken to 0x80, first encounter → MispredictE=1, RecoverPCE=0x80. Next fetch of 0x40 → PredTakenF=1, PredTargetF=0x80.
- Loop branch at 0x40 taken 3×, then not taken → counter reaches ST. Exit gives MispredictE=1, RecoverPCE=0x44. Counter becomes WT, and the next fetch still predicts taken.
- Stall held 2 cycles with a predicted-taken branch in D → D slot holds, E sees bubbles (MispredictE=0). Released → resolves correctly, single training.
- Aliasing: 0x40 allocated, then 0x440 (same index, tag differs) fetched → PredTakenF=0. 0x440 taken → overwrites the entry, and 0x40 then misses.
- Assert rst during a mispredict cycle → MispredictE=0 immediately, all entries invalid, PredTakenF=0 for every PCF.

Source files
------------

// File: rtl/bp_pkg.sv
// +-----------------------------------------------------------------------+
// | bp_pkg: shared types and helpers for the BTB branch predictor.        |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package bp_pkg;

  localparam int BP_INDEX_BITS = 4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } bp_ctr_t;

  typedef struct packed {
    logic        valid;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bp_slot_t;

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken);
    logic [1:0] c;
    c = ctr;
    if (taken) begin
      if (c != 2'b11) c = c + 2'd1;
    end else begin
      if (c != 2'b00) c = c - 2'd1;
    end
    return bp_ctr_t'(c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/btb_table.sv
// +-----------------------------------------------------------------------+
// | btb_table: direct-mapped BTB storage, two combinational read ports,   |
// | one synchronous write port. Rev 1.0                                   |
// +-----------------------------------------------------------------------+
`default_nettype none

module btb_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_BITS-1:0]  rd_idx_i,
  input  logic [29-INDEX_BITS:0] rd_tag_i,
  output logic                   rd_hit_o,
  output logic [1:0]             rd_ctr_o,
  output logic [31:0]            rd_target_o,
  input  logic [INDEX_BITS-1:0]  up_idx_i,
  input  logic [29-INDEX_BITS:0] up_tag_i,
  output logic                   up_hit_o,
  output logic [1:0]             up_ctr_o,
  output logic [31:0]            up_target_o,
  input  logic                   we_i,
  input  logic [INDEX_BITS-1:0]  wr_idx_i,
  input  logic [29-INDEX_BITS:0] wr_tag_i,
  input  logic [31:0]            wr_target_i,
  input  logic [1:0]             wr_ctr_i
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (we_i) begin
      valid_q[wr_idx_i]  <= 1'b1;
      tag_q[wr_idx_i]    <= wr_tag_i;
      target_q[wr_idx_i] <= wr_target_i;
      ctr_q[wr_idx_i]    <= wr_ctr_i;
    end
  end

  // Reads see the pre-write contents; a same-cycle update lands on the next cycle.
  assign rd_hit_o    = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_ctr_o    = ctr_q[rd_idx_i];
  assign rd_target_o = target_q[rd_idx_i];

  assign up_hit_o    = valid_q[up_idx_i] && (tag_q[up_idx_i] == up_tag_i);
  assign up_ctr_o    = ctr_q[up_idx_i];
  assign up_target_o = target_q[up_idx_i];

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// +-----------------------------------------------------------------------+
// | branch_predictor: BTB lookup in Fetch, prediction tracking to Execute,|
// | mispredict detection and table training. Rev 1.0                      |
// +-----------------------------------------------------------------------+
`default_nettype none

module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = BP_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchE,
  input  logic        TakenE,
  input  logic [31:0] TargetE,
  input  logic [31:0] PCE,
  output logic        MispredictE,
  output logic [31:0] RecoverPCE
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic                w_f_hit;
  logic [1:0]          w_f_ctr;
  logic [31:0]         w_f_target;
  logic                w_e_hit;
  logic [1:0]          w_e_ctr;
  logic [31:0]         w_e_target;
  logic                w_we;
  bp_ctr_t             w_wr_ctr;
  logic [31:0]         w_wr_target;
  logic                w_mispredict;
  logic                w_unused;

  bp_slot_t d_q, d_d;
  bp_slot_t e_q, e_d;

  assign w_unused = ^PCF[1:0];

  btb_table #(
    .INDEX_BITS (INDEX_BITS)
  ) u_btb (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_i    (PCF[INDEX_BITS+1:2]),
    .rd_tag_i    (PCF[31:INDEX_BITS+2]),
    .rd_hit_o    (w_f_hit),
    .rd_ctr_o    (w_f_ctr),
    .rd_target_o (w_f_target),
    .up_idx_i    (PCE[INDEX_BITS+1:2]),
    .up_tag_i    (PCE[31:INDEX_BITS+2]),
    .up_hit_o    (w_e_hit),
    .up_ctr_o    (w_e_ctr),
    .up_target_o (w_e_target),
    .we_i        (w_we),
    .wr_idx_i    (PCE[INDEX_BITS+1:2]),
    .wr_tag_i    (PCE[31:INDEX_BITS+2]),
    .wr_target_i (w_wr_target),
    .wr_ctr_i    (w_wr_ctr)
  );

  assign PredTakenF  = w_f_hit & w_f_ctr[1];
  assign PredTargetF = w_f_target;

  always_comb begin
    w_mispredict = 1'b0;
    if (e_q.valid) begin
      if (BranchE) begin
        w_mispredict = (e_q.pred_taken != TakenE) ||
                       (e_q.pred_taken && TakenE && (e_q.pred_target != TargetE));
      end else begin
        w_mispredict = e_q.pred_taken;
      end
    end
  end

  assign MispredictE = w_mispredict;
  assign RecoverPCE  = TakenE ? TargetE : (PCE + 32'd4);

  // Hits train the counter; only taken misses allocate, starting weakly taken.
  always_comb begin
    w_we        = 1'b0;
    w_wr_ctr    = CTR_WT;
    w_wr_target = TargetE;
    if (e_q.valid && BranchE) begin
      if (w_e_hit) begin
        w_we        = 1'b1;
        w_wr_ctr    = ctr_next(bp_ctr_t'(w_e_ctr), TakenE);
        w_wr_target = TakenE ? TargetE : w_e_target;
      end else if (TakenE) begin
        w_we = 1'b1;
      end
    end
  end

  always_comb begin
    d_d = d_q;
    e_d = e_q;
    if (w_mispredict) begin
      d_d = '0;
      e_d = '0;
    end else if (Stall) begin
      e_d = '0;
    end else begin
      d_d.valid       = 1'b1;
      d_d.pred_taken  = PredTakenF;
      d_d.pred_target = PredTargetF;
      e_d             = d_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= '0;
      e_q <= '0;
    end else begin
      d_q <= d_d;
      e_q <= e_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// +-----------------------------------------------------------------------+
// | tb_branch_predictor: directed + random stimulus against a behavioural |
// | BTB/pipeline model. Rev 1.0                                           |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Stall = 1'b0;
  logic [31:0] PCF = '0;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchE = 1'b0;
  logic        TakenE = 1'b0;
  logic [31:0] TargetE = '0;
  logic [31:0] PCE = '0;
  logic        MispredictE;
  logic [31:0] RecoverPCE;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk         (clk),
    .rst         (rst),
    .Stall       (Stall),
    .PCF         (PCF),
    .PredTakenF  (PredTakenF),
    .PredTargetF (PredTargetF),
    .BranchE     (BranchE),
    .TakenE      (TakenE),
    .TargetE     (TargetE),
    .PCE         (PCE),
    .MispredictE (MispredictE),
    .RecoverPCE  (RecoverPCE)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: table indexed by PC[5:2], counters as integers 0..3.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          md_v, md_pt, me_v, me_pt;
  logic [31:0] md_tgt, md_pc, me_tgt, me_pc;

  logic        obs_pt, obs_mis, rb_pt;
  logic [31:0] obs_ptgt, obs_rec, rb_ptgt;

  logic [31:0] pcs  [8] = '{32'h40, 32'h44, 32'h80, 32'h440, 32'h84, 32'h1040, 32'h3c, 32'h200};
  logic [31:0] tgts [4] = '{32'h80, 32'h44, 32'h500, 32'h1000};

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    md_v = 1'b0;
    me_v = 1'b0;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[pc[5:2]] && (m_tag[pc[5:2]] == pc[31:6]);
  endfunction

  // One clock: drive, check combinational outputs mid-cycle, clock, advance model.
  task automatic cyc(input logic [31:0] pcf, input bit stall, input bit br, input bit tk,
                     input logic [31:0] tgt, input logic [31:0] bubble_pce);
    bit          e_pt, e_mis;
    logic [31:0] e_tgt, e_rec;
    int          ei;
    PCF     = pcf;
    Stall   = stall;
    BranchE = br;
    TakenE  = br & tk;
    TargetE = tgt;
    PCE     = me_v ? me_pc : bubble_pce;
    #2;
    e_pt  = m_hit(pcf) && (m_ctr[pcf[5:2]] >= 2);
    e_tgt = m_tgt[pcf[5:2]];
    e_mis = 1'b0;
    if (me_v)
      e_mis = br ? ((me_pt != TakenE) || (me_pt && TakenE && (me_tgt != tgt))) : me_pt;
    e_rec = TakenE ? tgt : PCE + 32'd4;
    obs_pt   = PredTakenF;
    obs_ptgt = PredTargetF;
    obs_mis  = MispredictE;
    obs_rec  = RecoverPCE;
    check("pred_taken", PredTakenF, e_pt);
    if (e_pt) check("pred_target", PredTargetF, e_tgt);
    check("mispredict", MispredictE, e_mis);
    check("recover_pc", RecoverPCE, e_rec);
    @(posedge clk);
    #1;
    if (me_v && br) begin
      ei = PCE[5:2];
      if (m_hit(PCE)) begin
        m_ctr[ei] = TakenE ? ((m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1)
                           : ((m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1);
        if (TakenE) m_tgt[ei] = tgt;
      end else if (TakenE) begin
        m_valid[ei] = 1'b1;
        m_tag[ei]   = PCE[31:6];
        m_tgt[ei]   = tgt;
        m_ctr[ei]   = 2;
      end
    end
    if (e_mis) begin
      md_v = 1'b0;
      me_v = 1'b0;
    end else if (stall) begin
      me_v = 1'b0;
    end else begin
      me_v   = md_v;
      me_pt  = md_pt;
      me_tgt = md_tgt;
      me_pc  = md_pc;
      md_v   = 1'b1;
      md_pt  = e_pt;
      md_tgt = e_tgt;
      md_pc  = pcf;
    end
  endtask

  // Fetch pc, a filler, then resolve pc in Execute.
  task automatic run_branch(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    cyc(pc, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rb_pt   = obs_pt;
    rb_ptgt = obs_ptgt;
    cyc(32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(32'h204, 1'b0, 1'b1, tk, tgt, 32'h0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    PCF = 32'h100;
    #1;
    check("rst_pred_taken", PredTakenF, 1'b0);
    check("rst_pred_target", PredTargetF, 32'h0);
    check("rst_mispredict", MispredictE, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Not-taken branch on an empty table: no mispredict, no allocation.
    cyc(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(32'h204, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    check("nt_first_mis", obs_mis, 1'b0);
    cyc(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("nt_no_alloc", obs_pt, 1'b0);

    // First taken encounter, then loop and exit.
    run_branch(32'h40, 1'b1, 32'h80);
    check("first_taken_mis", obs_mis, 1'b1);
    check("first_taken_rec", obs_rec, 32'h80);
    run_branch(32'h40, 1'b1, 32'h80);
    check("alloc_pred", rb_pt, 1'b1);
    check("alloc_target", rb_ptgt, 32'h80);
    check("loop_no_mis", obs_mis, 1'b0);
    run_branch(32'h40, 1'b1, 32'h80);
    run_branch(32'h40, 1'b0, 32'h0);
    check("exit_pred", rb_pt, 1'b1);
    check("exit_mis", obs_mis, 1'b1);
    check("exit_rec", obs_rec, 32'h44);
    run_branch(32'h40, 1'b1, 32'h80);
    check("after_exit_pred", rb_pt, 1'b1);
    run_branch(32'h40, 1'b0, 32'h0);

    // Two stall cycles with a predicted-taken branch in D; bubbles offer a not-taken branch.
    cyc(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("stall_pred", obs_pt, 1'b1);
    cyc(32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 32'h40);
    cyc(32'h200, 1'b1, 1'b1, 1'b0, 32'h0, 32'h40);
    check("stall_bubble_mis", obs_mis, 1'b0);
    cyc(32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 32'h40);
    check("release_bubble_mis", obs_mis, 1'b0);
    cyc(32'h204, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0);
    check("stall_resolve_mis", obs_mis, 1'b0);
    run_branch(32'h40, 1'b1, 32'h80);
    check("single_train", rb_pt, 1'b1);

    // Aliasing at index 0 with a different tag.
    run_branch(32'h440, 1'b1, 32'h500);
    check("alias_miss", rb_pt, 1'b0);
    check("alias_mis", obs_mis, 1'b1);
    check("alias_rec", obs_rec, 32'h500);
    run_branch(32'h40, 1'b0, 32'h0);
    check("evicted_pred", rb_pt, 1'b0);

    // Reset asserted while a mispredict is being signalled.
    cyc(32'h440, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    PCF = 32'h208; Stall = 1'b0; BranchE = 1'b1; TakenE = 1'b0; TargetE = 32'h0; PCE = 32'h440;
    #2;
    check("pre_rst_mis", MispredictE, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_mis", MispredictE, 1'b0);
    check("rst_mid_rec", RecoverPCE, 32'h444);
    for (int i = 0; i < 4; i++) begin
      PCF = pcs[i];
      #1;
      check("rst_all_invalid", PredTakenF, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_reset();

    // Random traffic against the model.
    for (int n = 0; n < 800; n++) begin
      logic [31:0] r_pcf;
      bit          r_stall, r_br, r_tk;
      r_pcf   = pcs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      r_stall = ($urandom_range(0, 4) == 0);
      r_br    = ($urandom_range(0, 9) < 6);
      r_tk    = ($urandom_range(0, 2) != 0);
      cyc(r_pcf, r_stall, r_br, r_tk, tgts[$urandom_range(0, 3)], pcs[$urandom_range(0, 7)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
